// File: rtl/scan_decoder_nto2n.sv
// Registered N-to-2^N one-hot select decoder with a built-in programmable scan sequencer.
// Optional feature macro: SCAN_DECODER_BLANK_EN (blank y on the first cycle of each scan step).
module scan_decoder_nto2n #(
  parameter int unsigned SEL_W      = 3,
  parameter int unsigned DIV_W      = 16,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      x,
  input  logic [DIV_W-1:0]      div,
  input  logic [SEL_W-1:0]      scan_last,
  output logic [2**SEL_W-1:0]   y,
  output logic [SEL_W-1:0]      idx,
  output logic                  wrap
);

  localparam int unsigned OUT_W = 2 ** SEL_W;
  localparam logic [OUT_W-1:0] INACTIVE = {OUT_W{ACTIVE_LOW}};

  typedef enum logic [1:0] {
    IDLE,
    DIRECT,
    SCAN
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] cnt;

  logic             at_last_c;
  logic             tick_c;
  logic [SEL_W-1:0] step_idx_c;

  // Select pattern for index i in the configured polarity.
  function automatic logic [OUT_W-1:0] drive(input logic [SEL_W-1:0] i);
    return (OUT_W'(1) << i) ^ INACTIVE;
  endfunction

  assign at_last_c  = (idx >= scan_last);
  assign tick_c     = (cnt == div);
  assign step_idx_c = at_last_c ? '0 : idx + SEL_W'(1);

  always_ff @(posedge clk) begin
    if (reset || !en) begin
      state <= IDLE;
      y     <= INACTIVE;
      idx   <= '0;
      wrap  <= 1'b0;
      cnt   <= '0;
    end else if (!mode) begin
      state <= DIRECT;
      y     <= drive(x);
      idx   <= x;
      wrap  <= 1'b0;
      cnt   <= '0;
    end else if (state != SCAN) begin
      // Scan entry always restarts from index 0 without a wrap pulse.
      state <= SCAN;
      idx   <= '0;
      wrap  <= 1'b0;
      cnt   <= '0;
`ifdef SCAN_DECODER_BLANK_EN
      y     <= (div == '0) ? drive('0) : INACTIVE;
`else
      y     <= drive('0);
`endif
    end else if (tick_c) begin
      state <= SCAN;
      idx   <= step_idx_c;
      wrap  <= at_last_c;
      cnt   <= '0;
`ifdef SCAN_DECODER_BLANK_EN
      y     <= (div == '0) ? drive(step_idx_c) : INACTIVE;
`else
      y     <= drive(step_idx_c);
`endif
    end else begin
      // cnt may exceed a freshly lowered div; it then wraps at 2^DIV_W.
      state <= SCAN;
      idx   <= idx;
      wrap  <= 1'b0;
      cnt   <= cnt + DIV_W'(1);
      y     <= drive(idx);
    end
  end

endmodule
